// File: rtl/date_pkg.sv
// Shared types and helpers for the date stepper: FSM state encoding,
// the Gregorian non-leap month-length table and the date range check.
package date_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MONTH_DAYS [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  // Out-of-range months map to length 0 so any day fails the range check.
  function automatic int unsigned table_len(input int unsigned month);
    logic [3:0] idx;
    idx = 4'(month - 1);
    if (month >= 1 && month <= 12) return MONTH_DAYS[idx];
    return 0;
  endfunction

  function automatic bit is_valid_date(input int unsigned day,
                                       input int unsigned month,
                                       input int unsigned len,
                                       input int unsigned months);
    return (month >= 1) && (month <= months) && (day >= 1) && (day <= len);
  endfunction

endpackage

// File: rtl/date_stepper_if.sv
// Load/step handshake and date status bundle between a controller and date_stepper.
interface date_stepper_if #(
  parameter int DAY_W   = 5,
  parameter int MONTH_W = 4,
  parameter int STEP_W  = 4
);
  logic               load_valid;
  logic [DAY_W-1:0]   load_day;
  logic [MONTH_W-1:0] load_month;
  logic               step_valid;
  logic [STEP_W-1:0]  step_count;
  logic               step_ready;
  logic [DAY_W-1:0]   day;
  logic [MONTH_W-1:0] month;
  logic               busy;
  logic               done;
  logic               wrap;
  logic               err;

  modport master (
    output load_valid, load_day, load_month, step_valid, step_count,
    input  step_ready, day, month, busy, done, wrap, err
  );

  modport slave (
    input  load_valid, load_day, load_month, step_valid, step_count,
    output step_ready, day, month, busy, done, wrap, err
  );
endinterface

// File: rtl/month_len.sv
// Combinational month -> length lookup. With MONTH_TABLE_EN defined the
// Gregorian non-leap table is used, otherwise every month is DAYS_PER_MONTH long.
module month_len
  import date_pkg::*;
#(
  parameter int MONTH_W        = 4,
  parameter int DAY_W          = 5,
  parameter int DAYS_PER_MONTH = 30
) (
  input  logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   len
);

`ifdef MONTH_TABLE_EN
  localparam int unused_dpm = DAYS_PER_MONTH;
  assign len = DAY_W'(table_len(32'(month)));
`else
  logic unused_month;
  assign unused_month = ^month;
  assign len = DAY_W'(DAYS_PER_MONTH);
`endif

endmodule

// File: rtl/date_stepper.sv
// Registered calendar date that advances one day per clock on a step command.
// MONTH_TABLE_EN selects real month lengths (requires MONTHS == 12).
//
// state | meaning
// IDLE  | accepts loads and step commands
// RUN   | advancing one day per clock, cnt days remaining
// DONE  | one-cycle completion pulse, back to IDLE
module date_stepper
  import date_pkg::*;
#(
  parameter int DAY_W          = 5,
  parameter int MONTH_W        = 4,
  parameter int STEP_W         = 4,
  parameter int DAYS_PER_MONTH = 30,
  parameter int MONTHS         = 12
) (
  input logic           clk,
  input logic           rst,
  date_stepper_if.slave bus
);

`ifdef MONTH_TABLE_EN
  if (MONTHS != 12) begin : g_bad_months
    $error("date_stepper: month table requires MONTHS == 12");
  end
`endif

  state_t             state, next_state;
  logic [STEP_W-1:0]  cnt;
  logic [DAY_W-1:0]   day_q;
  logic [MONTH_W-1:0] month_q;
  logic               wrap_q;
  logic               err_q;
  logic [DAY_W-1:0]   cur_len;
  logic [DAY_W-1:0]   load_len;
  logic               load_ok;
  logic               step_accept;

  month_len #(.MONTH_W(MONTH_W), .DAY_W(DAY_W), .DAYS_PER_MONTH(DAYS_PER_MONTH)) u_len_cur (
    .month (month_q),
    .len   (cur_len)
  );

  month_len #(.MONTH_W(MONTH_W), .DAY_W(DAY_W), .DAYS_PER_MONTH(DAYS_PER_MONTH)) u_len_load (
    .month (bus.load_month),
    .len   (load_len)
  );

  assign load_ok = is_valid_date(32'(bus.load_day), 32'(bus.load_month),
                                 32'(load_len), MONTHS);

  // A pending load always takes priority over a step in the same cycle.
  assign bus.step_ready = (state == IDLE) && !err_q && !bus.load_valid;
  assign step_accept    = bus.step_valid && bus.step_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (step_accept) next_state = (bus.step_count == '0) ? DONE : RUN;
      RUN:  if (cnt == STEP_W'(1)) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q   <= DAY_W'(1);
      month_q <= MONTH_W'(1);
      cnt     <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            if (load_ok) begin
              day_q   <= bus.load_day;
              month_q <= bus.load_month;
              err_q   <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end else if (step_accept) begin
            cnt <= bus.step_count;
          end
        end
        RUN: begin
          if (day_q == cur_len) begin
            day_q <= DAY_W'(1);
            if (month_q == MONTH_W'(MONTHS)) begin
              month_q <= MONTH_W'(1);
              wrap_q  <= 1'b1;
            end else begin
              month_q <= month_q + MONTH_W'(1);
            end
          end else begin
            day_q <= day_q + DAY_W'(1);
          end
          cnt <= cnt - STEP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.day   = day_q;
  assign bus.month = month_q;
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

endmodule
